// File: rtl/dcache_tag_ctrl_if.sv
// Bundle between the MEM-stage requester, the 2-way tag RAM, the L2 port and the tag controller.
interface dcache_tag_ctrl_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TAG_W  = 21;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned THR_W  = 2;

  logic              req_en;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [THR_W-1:0]  req_thread;
  logic              busy;
  logic              done;
  logic              hit;
  logic              hit_way;

  logic [IDX_W-1:0]  index;
  logic              block0_re;
  logic              block1_re;
  logic              block0_we;
  logic              block1_we;
  logic [TAG_W-1:0]  tag_wd;
  logic [THR_W-1:0]  thread_wd;
  logic              data_wd_dc_en;
  logic              l2_wr_dc_en;
  logic [TAG_W-1:0]  tag0_rd;
  logic [TAG_W-1:0]  tag1_rd;
  logic [THR_W-1:0]  thread0;
  logic [THR_W-1:0]  thread1;
  logic              dirty0;
  logic              dirty1;
  logic              lru;

  logic              l2_req;
  logic              l2_rw;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_ack;

  modport slave (
    input  req_en, req_rw, req_addr, req_thread,
    input  tag0_rd, tag1_rd, thread0, thread1, dirty0, dirty1, lru,
    input  l2_ack,
    output busy, done, hit, hit_way,
    output index, block0_re, block1_re, block0_we, block1_we,
    output tag_wd, thread_wd, data_wd_dc_en, l2_wr_dc_en,
    output l2_req, l2_rw, l2_addr
  );

  modport master (
    output req_en, req_rw, req_addr, req_thread,
    output tag0_rd, tag1_rd, thread0, thread1, dirty0, dirty1, lru,
    output l2_ack,
    input  busy, done, hit, hit_way,
    input  index, block0_re, block1_re, block0_we, block1_we,
    input  tag_wd, thread_wd, data_wd_dc_en, l2_wr_dc_en,
    input  l2_req, l2_rw, l2_addr
  );
endinterface

// File: rtl/dcache_tag_ctrl.sv
// 2-way D-cache tag lookup / miss controller: hit compare, victim pick, writeback, refill, fill.
// Tag RAM controls decode from state in the same cycle so a lookup resolves one cycle after acceptance.
module dcache_tag_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  dcache_tag_ctrl_if.slave bus
);
  localparam int unsigned TAG_W = 21;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned THR_W = 2;
  localparam int unsigned SETS  = 256;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WB     = 3'd2,
    S_REFILL = 3'd3,
    S_FILL   = 3'd4,
    S_RELOOK = 3'd5
  } state_t;

  state_t           r_state;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] r_vtag;
  logic [IDX_W-1:0] r_index;
  logic [THR_W-1:0] r_thread;
  logic             r_rw;
  logic             r_first;
  logic             r_victim;
  logic [SETS-1:0]  r_valid0;
  logic [SETS-1:0]  r_valid1;

  logic             w_val0;
  logic             w_val1;
  logic             w_hit0;
  logic             w_hit1;
  logic             w_hit;
  logic             w_hit_way;
  logic             w_victim;
  logic             w_vdirty;
  logic [TAG_W-1:0] w_vtag;
  logic             w_unused_addr;

  assign w_val0    = r_valid0[r_index];
  assign w_val1    = r_valid1[r_index];
  assign w_hit0    = w_val0 && (bus.tag0_rd == r_tag) && (bus.thread0 == r_thread);
  assign w_hit1    = w_val1 && (bus.tag1_rd == r_tag) && (bus.thread1 == r_thread);
  assign w_hit     = w_hit0 | w_hit1;
  // A double hit is illegal; way0 wins.
  assign w_hit_way = ~w_hit0;

  // Prefer an invalid way (way0 first); with both valid, evict the less recent way.
  assign w_victim  = !w_val0 ? 1'b0 : (!w_val1 ? 1'b1 : bus.lru);
  assign w_vtag    = w_victim ? bus.tag1_rd : bus.tag0_rd;
  assign w_vdirty  = w_val0 && w_val1 && (w_victim ? bus.dirty1 : bus.dirty0);

  assign w_unused_addr = ^bus.req_addr[2:0];

  // State and request/victim registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_tag    <= '0;
      r_vtag   <= '0;
      r_index  <= '0;
      r_thread <= '0;
      r_rw     <= 1'b0;
      r_first  <= 1'b0;
      r_victim <= 1'b0;
      r_valid0 <= '0;
      r_valid1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_en) begin
            r_tag    <= bus.req_addr[31:11];
            r_index  <= bus.req_addr[10:3];
            r_thread <= bus.req_thread;
            r_rw     <= bus.req_rw;
            r_first  <= 1'b1;
            r_state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_victim <= w_victim;
            r_vtag   <= w_vtag;
            r_first  <= 1'b0;
            r_state  <= w_vdirty ? S_WB : S_REFILL;
          end
        end
        S_WB: begin
          if (bus.l2_ack) r_state <= S_REFILL;
        end
        S_REFILL: begin
          if (bus.l2_ack) r_state <= S_FILL;
        end
        S_FILL: begin
          if (r_victim) r_valid1[r_index] <= 1'b1;
          else          r_valid0[r_index] <= 1'b1;
          r_state <= S_RELOOK;
        end
        S_RELOOK: r_state <= S_LOOKUP;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    bus.busy          = (r_state != S_IDLE);
    bus.done          = 1'b0;
    bus.hit           = 1'b0;
    bus.hit_way       = 1'b0;
    bus.index         = '0;
    bus.block0_re     = 1'b0;
    bus.block1_re     = 1'b0;
    bus.block0_we     = 1'b0;
    bus.block1_we     = 1'b0;
    bus.tag_wd        = '0;
    bus.thread_wd     = '0;
    bus.data_wd_dc_en = 1'b0;
    bus.l2_wr_dc_en   = 1'b0;
    bus.l2_req        = 1'b0;
    bus.l2_rw         = 1'b0;
    bus.l2_addr       = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_en) begin
          bus.index     = bus.req_addr[10:3];
          bus.block0_re = 1'b1;
          bus.block1_re = 1'b1;
        end
      end
      S_LOOKUP: begin
        bus.index = r_index;
        if (w_hit) begin
          bus.done    = 1'b1;
          bus.hit     = r_first;
          bus.hit_way = w_hit_way;
          if (r_rw) begin
            bus.block0_we     = ~w_hit_way;
            bus.block1_we     = w_hit_way;
            bus.data_wd_dc_en = 1'b1;
            bus.tag_wd        = r_tag;
            bus.thread_wd     = r_thread;
          end
        end
      end
      S_WB: begin
        bus.index   = r_index;
        bus.l2_req  = 1'b1;
        bus.l2_rw   = 1'b1;
        bus.l2_addr = {r_vtag, r_index, 3'b000};
      end
      S_REFILL: begin
        bus.index   = r_index;
        bus.l2_req  = 1'b1;
        bus.l2_addr = {r_tag, r_index, 3'b000};
      end
      S_FILL: begin
        bus.index       = r_index;
        bus.block0_we   = ~r_victim;
        bus.block1_we   = r_victim;
        bus.l2_wr_dc_en = 1'b1;
        bus.tag_wd      = r_tag;
        bus.thread_wd   = r_thread;
      end
      S_RELOOK: begin
        bus.index     = r_index;
        bus.block0_re = 1'b1;
        bus.block1_re = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Scoreboard bench for dcache_tag_ctrl: behavioural tag RAM and L2 responder, queued expectations.
module tb_dcache_tag_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_tag_ctrl_if bus();
  dcache_tag_ctrl u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_acc = 0;
  int ack_delay = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic hit; logic way; int lat; } done_t;
  typedef struct { logic rw; logic [31:0] addr; } l2_t;
  typedef struct { logic way; logic [7:0] idx; logic [20:0] tag; logic [1:0] thr; logic store; int lat; } wr_t;
  done_t q_done[$];
  l2_t   q_l2[$];
  wr_t   q_wr[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ad(input logic [20:0] t, input logic [7:0] i);
    return {t, i, 3'b000};
  endfunction

  task automatic exp_done(input logic h, input logic w, input int lat);
    done_t d;
    d.hit = h; d.way = w; d.lat = lat;
    q_done.push_back(d);
  endtask

  task automatic exp_l2(input logic rw, input logic [31:0] a);
    l2_t e;
    e.rw = rw; e.addr = a;
    q_l2.push_back(e);
  endtask

  task automatic exp_wr(input logic way, input logic [7:0] idx, input logic [20:0] tag,
                        input logic [1:0] thr, input logic store, input int lat);
    wr_t w;
    w.way = way; w.idx = idx; w.tag = tag; w.thr = thr; w.store = store; w.lat = lat;
    q_wr.push_back(w);
  endtask

  // Tag RAM model: one-cycle read latency, write sets/clears dirty and updates LRU.
  logic [20:0] m_tag [2][256] = '{default: '0};
  logic [1:0]  m_thr [2][256] = '{default: '0};
  logic        m_dirty [2][256] = '{default: 1'b0};
  logic        m_lru [256] = '{default: 1'b0};
  always @(posedge clk) begin
    if (bus.block0_we) begin
      m_tag[0][bus.index] <= bus.tag_wd;
      m_thr[0][bus.index] <= bus.thread_wd;
      m_dirty[0][bus.index] <= bus.data_wd_dc_en;
      m_lru[bus.index] <= 1'b1;
    end
    if (bus.block1_we) begin
      m_tag[1][bus.index] <= bus.tag_wd;
      m_thr[1][bus.index] <= bus.thread_wd;
      m_dirty[1][bus.index] <= bus.data_wd_dc_en;
      m_lru[bus.index] <= 1'b0;
    end
    if (bus.block0_re) begin
      bus.tag0_rd <= m_tag[0][bus.index];
      bus.thread0 <= m_thr[0][bus.index];
      bus.dirty0  <= m_dirty[0][bus.index];
      bus.lru     <= m_lru[bus.index];
    end
    if (bus.block1_re) begin
      bus.tag1_rd <= m_tag[1][bus.index];
      bus.thread1 <= m_thr[1][bus.index];
      bus.dirty1  <= m_dirty[1][bus.index];
    end
  end

  // Monitor: completions and tag RAM writes against the queues.
  always @(negedge clk) begin : mon
    done_t d;
    wr_t   w;
    if (rst_n) begin
      if (bus.done) begin
        if (q_done.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
        else begin
          d = q_done.pop_front();
          chk("hit", 64'(bus.hit), 64'(d.hit));
          chk("hit_way", 64'(bus.hit_way), 64'(d.way));
          chk("done_latency", 64'(cyc - t_acc), 64'(d.lat));
        end
      end
      if (bus.block0_we || bus.block1_we) begin
        if (q_wr.size() == 0) chk("unexpected_write", 64'(1), 64'(0));
        else begin
          w = q_wr.pop_front();
          chk("wr_way", 64'({bus.block1_we, bus.block0_we}), w.way ? 64'(2) : 64'(1));
          chk("wr_index", 64'(bus.index), 64'(w.idx));
          chk("wr_tag", 64'(bus.tag_wd), 64'(w.tag));
          chk("wr_thread", 64'(bus.thread_wd), 64'(w.thr));
          chk("wr_kind", 64'({bus.data_wd_dc_en, bus.l2_wr_dc_en}), w.store ? 64'(2) : 64'(1));
          chk("wr_latency", 64'(cyc - t_acc), 64'(w.lat));
        end
      end else if (bus.busy) begin
        chk("dc_en_without_we", 64'({bus.data_wd_dc_en, bus.l2_wr_dc_en}), 64'(0));
      end
    end
  end

  // L2 responder: checks each request phase, holds ack off ack_delay cycles, checks stability.
  initial begin : l2_resp
    l2_t         e;
    logic [31:0] a0;
    logic        r0;
    logic        stable;
    logic        aborted;
    bus.l2_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.l2_ack = 1'b0;
      if (rst_n && bus.l2_req) begin
        if (q_l2.size() == 0) chk("unexpected_l2_req", 64'(1), 64'(0));
        else begin
          e = q_l2.pop_front();
          chk("l2_rw", 64'(bus.l2_rw), 64'(e.rw));
          chk("l2_addr", 64'(bus.l2_addr), 64'(e.addr));
        end
        a0 = bus.l2_addr; r0 = bus.l2_rw; stable = 1'b1; aborted = 1'b0;
        for (int k = 0; k < ack_delay; k++) begin
          @(negedge clk);
          if (!rst_n || !bus.l2_req) begin aborted = 1'b1; break; end
          if (bus.l2_addr !== a0 || bus.l2_rw !== r0 || !bus.busy) stable = 1'b0;
        end
        if (!aborted) begin
          bus.l2_ack = 1'b1;
          if (ack_delay > 0) chk("l2_hold_stable", 64'(stable), 64'(1));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic rw, input logic [1:0] th);
    int guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 500) begin @(negedge clk); guard++; end
    t_acc = cyc;
    bus.req_en = 1'b1; bus.req_rw = rw; bus.req_addr = a; bus.req_thread = th;
    @(negedge clk);
    bus.req_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((q_done.size() != 0 || bus.busy) && n < 300) begin @(negedge clk); n++; end
    chk({"complete_", name}, 64'(n < 300), 64'(1));
  endtask

  initial begin
    bus.req_en = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_thread = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'({bus.busy, bus.done, bus.hit, bus.hit_way, bus.index, bus.block0_re, bus.block1_re,
                          bus.block0_we, bus.block1_we, bus.data_wd_dc_en, bus.l2_wr_dc_en,
                          bus.l2_req, bus.l2_rw, bus.thread_wd}), 64'(0));
    chk("reset_data", 64'({bus.tag_wd, bus.l2_addr}), 64'(0));
    rst_n = 1'b1;

    // Clean miss into empty way0, then load hit, then store hit.
    exp_l2(1'b0, 32'h0000_1008); exp_wr(1'b0, 8'h01, 21'd2, 2'd0, 1'b0, 3); exp_done(1'b0, 1'b0, 5);
    issue(32'h0000_1008, 1'b0, 2'd0); wait_done("miss_empty");
    exp_done(1'b1, 1'b0, 1);
    issue(32'h0000_1008, 1'b0, 2'd0); wait_done("load_hit");
    exp_wr(1'b0, 8'h01, 21'd2, 2'd0, 1'b1, 1); exp_done(1'b1, 1'b0, 1);
    issue(32'h0000_1008, 1'b1, 2'd0); wait_done("store_hit");

    // Fill way1 of index 1, then a third tag evicts the dirty way0 line.
    exp_l2(1'b0, ad(21'd3, 8'h01)); exp_wr(1'b1, 8'h01, 21'd3, 2'd0, 1'b0, 3); exp_done(1'b0, 1'b1, 5);
    issue(ad(21'd3, 8'h01), 1'b0, 2'd0); wait_done("fill_way1");
    exp_l2(1'b1, 32'h0000_1008); exp_l2(1'b0, ad(21'd4, 8'h01));
    exp_wr(1'b0, 8'h01, 21'd4, 2'd0, 1'b0, 4); exp_done(1'b0, 1'b0, 6);
    issue(ad(21'd4, 8'h01), 1'b0, 2'd0); wait_done("dirty_evict");

    // Index 5: fill both ways, dirty way0, clean eviction of way1, then dirty eviction of way0.
    exp_l2(1'b0, ad(21'h10, 8'h05)); exp_wr(1'b0, 8'h05, 21'h10, 2'd0, 1'b0, 3); exp_done(1'b0, 1'b0, 5);
    issue(ad(21'h10, 8'h05), 1'b0, 2'd0); wait_done("idx5_a");
    exp_l2(1'b0, ad(21'h11, 8'h05)); exp_wr(1'b1, 8'h05, 21'h11, 2'd0, 1'b0, 3); exp_done(1'b0, 1'b1, 5);
    issue(ad(21'h11, 8'h05), 1'b0, 2'd0); wait_done("idx5_b");
    exp_wr(1'b0, 8'h05, 21'h10, 2'd0, 1'b1, 1); exp_done(1'b1, 1'b0, 1);
    issue(ad(21'h10, 8'h05), 1'b1, 2'd0); wait_done("idx5_store_a");
    exp_l2(1'b0, ad(21'h12, 8'h05)); exp_wr(1'b1, 8'h05, 21'h12, 2'd0, 1'b0, 3); exp_done(1'b0, 1'b1, 5);
    issue(ad(21'h12, 8'h05), 1'b0, 2'd0); wait_done("idx5_c_clean");

    // Dirty eviction with a 10-cycle L2 stall and ignored req_en pulses during the wait.
    ack_delay = 10;
    exp_l2(1'b1, ad(21'h10, 8'h05)); exp_l2(1'b0, ad(21'h13, 8'h05));
    exp_wr(1'b0, 8'h05, 21'h13, 2'd0, 1'b0, 24); exp_done(1'b0, 1'b0, 26);
    issue(ad(21'h13, 8'h05), 1'b0, 2'd0);
    repeat (4) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      bus.req_en = 1'b1; bus.req_rw = 1'b1; bus.req_addr = ad(21'h55, 8'h07); bus.req_thread = 2'd3;
      @(negedge clk);
      bus.req_en = 1'b0;
      @(negedge clk);
    end
    wait_done("idx5_d_stall");
    ack_delay = 0;

    // Same tag, other thread: miss; then each thread hits its own way.
    exp_l2(1'b0, ad(21'h13, 8'h05)); exp_wr(1'b1, 8'h05, 21'h13, 2'd1, 1'b0, 3); exp_done(1'b0, 1'b1, 5);
    issue(ad(21'h13, 8'h05), 1'b0, 2'd1); wait_done("thread_miss");
    exp_done(1'b1, 1'b1, 1);
    issue(ad(21'h13, 8'h05), 1'b0, 2'd1); wait_done("thread1_hit");
    exp_done(1'b1, 1'b0, 1);
    issue(ad(21'h13, 8'h05), 1'b0, 2'd0); wait_done("thread0_hit");

    // Store miss: fill, then the relookup hit writes again with dirty set.
    exp_l2(1'b0, ad(21'h20, 8'h09)); exp_wr(1'b0, 8'h09, 21'h20, 2'd2, 1'b0, 3);
    exp_wr(1'b0, 8'h09, 21'h20, 2'd2, 1'b1, 5); exp_done(1'b0, 1'b0, 5);
    issue(ad(21'h20, 8'h09), 1'b1, 2'd2); wait_done("store_miss");

    // Reset in the middle of REFILL.
    ack_delay = 20;
    exp_l2(1'b0, ad(21'h30, 8'h01));
    issue(ad(21'h30, 8'h01), 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_ctl", 64'({bus.busy, bus.done, bus.hit, bus.hit_way, bus.index, bus.block0_re, bus.block1_re,
                             bus.block0_we, bus.block1_we, bus.data_wd_dc_en, bus.l2_wr_dc_en,
                             bus.l2_req, bus.l2_rw, bus.thread_wd}), 64'(0));
    chk("midreset_data", 64'({bus.tag_wd, bus.l2_addr}), 64'(0));
    @(negedge clk);
    ack_delay = 0;
    rst_n = 1'b1;
    exp_l2(1'b0, ad(21'd4, 8'h01)); exp_wr(1'b0, 8'h01, 21'd4, 2'd0, 1'b0, 3); exp_done(1'b0, 1'b0, 5);
    issue(ad(21'd4, 8'h01), 1'b0, 2'd0); wait_done("post_reset_miss");

    repeat (3) @(negedge clk);
    chk("leftover_done", 64'(q_done.size()), 64'(0));
    chk("leftover_l2", 64'(q_l2.size()), 64'(0));
    chk("leftover_wr", 64'(q_wr.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
    $fatal(1, "watchdog");
  end
endmodule
